// File: rtl/sr_ff_driver_pkg.sv
// Shared definitions for the SR flip-flop bank driver: FSM state codes,
// {s,r} excitation codes and the per-bit excitation rule.
package sr_ff_driver_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'b00,
    SR_RESET   = 2'b01,
    SR_SET     = 2'b10,
    SR_INVALID = 2'b11
  } sr_code_e;

  // A bit whose modelled value is not trusted is always driven explicitly.
  function automatic sr_code_e sr_excitation(input logic known, input logic qm,
                                             input logic t);
    if (known && (qm == t)) return SR_HOLD;
    return t ? SR_SET : SR_RESET;
  endfunction

endpackage

// File: rtl/sr_excite.sv
// One-bit combinational excitation: chooses HOLD/SET/RESET for a single
// SR flip-flop from its modelled state and its target.
module sr_excite
  import sr_ff_driver_pkg::*;
(
  input  logic     known,
  input  logic     qm,
  input  logic     t,
  output sr_code_e sr
);

  assign sr = sr_excitation(known, qm, t);

endmodule

// File: rtl/sr_ff_driver.sv
// Excitation-side controller for a bank of SR flip-flops: accept target,
// drive {s,r} for one cycle, optionally verify q/qbar feedback.
// Feedback checking is built when SR_FF_DRIVER_CHECK_EN is defined.
module sr_ff_driver
  import sr_ff_driver_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q_fb,
  input  logic [WIDTH-1:0] qbar_fb,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_bits
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_qm;
  logic [WIDTH-1:0] r_known;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_r;
  logic             r_done;

  sr_code_e         w_sr [WIDTH];
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_rst;
  logic             w_accept;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    sr_excite u_excite (
      .known (r_known[gi]),
      .qm    (r_qm[gi]),
      .t     (tgt_data[gi]),
      .sr    (w_sr[gi])
    );
    assign w_set[gi] = w_sr[gi][1];
    assign w_rst[gi] = w_sr[gi][0];

    always_ff @(posedge clk) begin
      if (!rst) assert (w_sr[gi] != SR_INVALID);
    end
  end

  assign w_accept  = tgt_valid && (r_state == ST_IDLE);
  assign tgt_ready = (r_state == ST_IDLE);
  assign s         = r_s;
  assign r         = r_r;
  assign done      = r_done;

`ifdef SR_FF_DRIVER_CHECK_EN
  logic [WIDTH-1:0] r_tgt;
  logic             r_err;
  logic [WIDTH-1:0] r_err_bits;
  logic [WIDTH-1:0] w_mismatch;

  // A bit fails if either rail disagrees, catching inconsistent q==qbar too.
  assign w_mismatch = (q_fb ^ r_tgt) | (qbar_fb ^ ~r_tgt);
  assign err        = r_err;
  assign err_bits   = r_err_bits;
`else
  logic w_unused_fb;

  assign w_unused_fb = ^{q_fb, qbar_fb};
  assign err         = 1'b0;
  assign err_bits    = '0;
`endif

  // NOTE: every register here is updated with <= so all state advances
  // together on the edge; blocking assignments would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_qm       <= '0;
      r_known    <= '0;
      r_s        <= '0;
      r_r        <= '0;
      r_done     <= 1'b0;
`ifdef SR_FF_DRIVER_CHECK_EN
      r_tgt      <= '0;
      r_err      <= 1'b0;
      r_err_bits <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_DRIVE;
            r_s     <= w_set;
            r_r     <= w_rst;
            r_qm    <= tgt_data;
            r_known <= '1;
`ifdef SR_FF_DRIVER_CHECK_EN
            r_tgt   <= tgt_data;
`endif
          end
        end
        ST_DRIVE: begin
          r_s <= '0;
          r_r <= '0;
`ifdef SR_FF_DRIVER_CHECK_EN
          r_state <= ST_CHECK;
`else
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
`endif
        end
`ifdef SR_FF_DRIVER_CHECK_EN
        ST_CHECK: begin
          r_state    <= ST_IDLE;
          r_err_bits <= w_mismatch;
          r_err      <= r_err | (|w_mismatch);
          r_known    <= r_known & ~w_mismatch;
          r_done     <= 1'b1;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert ((r_s & r_r) == '0);
  end

endmodule

// File: doc/sr_ff_driver.md
# sr_ff_driver

Excitation-side controller for a bank of SR flip-flops: accepts a target bit vector over a valid/ready handshake, computes the per-bit {s,r} excitation that moves each flip-flop to its target, drives it for exactly one cycle, then checks the flip-flops' q/qbar feedback against the target. It sits in front of `sr_ff` instances and is the only agent driving their s/r inputs. It never issues the invalid {s,r}=2'b11 code.

## Interface
- `WIDTH`, 4: number of SR flip-flops driven, at least 1.
- `clk`  in  1  rising-edge clock, shared with the driven flip-flops.
- `rst`  in  1  synchronous, active-high reset.
- `tgt_valid`  in  1  target vector offered.
- `tgt_data`  in  WIDTH  desired q value per flip-flop.
- `tgt_ready`  out  1  block can accept a target (high only in IDLE).
- `s`  out  WIDTH  set excitation to flip-flop bank (registered).
- `r`  out  WIDTH  reset excitation to flip-flop bank (registered).
- `q_fb`  in  WIDTH  q outputs of the bank.
- `qbar_fb`  in  WIDTH  qbar outputs of the bank.
- `done`  out  1  one-cycle pulse: transfer complete.
- `err`  out  1  sticky: any check failure since reset.
- `err_bits`  out  WIDTH  failing bit mask of the most recent transfer (0 if it passed).

## Operation
- Internal state: `qm` (modelled q) and `known` (qm valid per bit). Reset: qm=0, known=0. The flip-flop powers up in an inconsistent state, so unknown bits are never assumed.
- Per-bit excitation for target t, computed on acceptance:
  - known and qm==t gives HOLD (s=0, r=0).
  - otherwise t=1 gives SET (s=1, r=0), and t=0 gives RESET (s=0, r=1).
- FSM states: IDLE, DRIVE, CHECK.
  - IDLE to DRIVE on tgt_valid & tgt_ready. tgt_data is captured, s/r are loaded with the excitation, qm<=target, known<=all ones.
  - DRIVE to CHECK unconditionally. s/r return to 0 on this edge.
  - CHECK to IDLE unconditionally. Compare q_fb==target and qbar_fb==~target per bit. err_bits<=mismatch mask, err<=err|(|mismatch), known<=known & ~mismatch, done<=1.
- s and r are 0 in every state except DRIVE. s&r is always 0.
- tgt_data is ignored outside the accept cycle. tgt_valid held high in DRIVE or CHECK has no effect.
- Reset mid-transfer:
  - Next edge returns to IDLE with s=r=0, done=0, err=0, err_bits=0, known=0.
  - An in-flight transfer is abandoned silently.
- Reset values: tgt_ready=1 (IDLE), s=0, r=0, done=0, err=0, err_bits=0.

## Timing
- Accept at edge E0.
- s/r are valid from E0 to E1. The flip-flops sample them at E1.
- q_fb/qbar_fb are compared during the E1 to E2 cycle and registered at E2.
- done is high from E2 to E3. tgt_ready is high again from E2, so a new target may be accepted at E3.
- Throughput: one transfer per 3 cycles. Latency from acceptance to done: 2 edges.
- err_bits and err update at the same edge that done rises. err_bits holds its value until the next done.
- A transfer whose bits are all HOLD still runs DRIVE with s=r=0 and performs the check.

## Configuration
- `SR_FF_DRIVER_CHECK_EN` defined: CHECK state, feedback comparison and err/err_bits are present as above.
- `SR_FF_DRIVER_CHECK_EN` undefined:
  - FSM is IDLE to DRIVE to IDLE. done rises at E1 and a new accept is possible at E2.
  - q_fb/qbar_fb are ignored and err=err_bits=0 constantly.
  - known is set by each drive and cleared only by rst.

## Structure
- Package `sr_ff_driver_pkg`:
  - state enum (IDLE, DRIVE, CHECK);
  - {s,r} codes HOLD=2'b00, RESET=2'b01, SET=2'b10, INVALID=2'b11 (INVALID is only for assertions).
- Sub-module `sr_excite`: combinational, one bit. Inputs known, qm, t; output {s,r}. Instantiated WIDTH times with a generate loop.
- Assertion: the {s,r} pair of no bit ever equals INVALID.

## Test plan
Bench: WIDTH=4, four behavioural SR flip-flops on s/r, feedback wired back.
- Reset, then target 4'b1010: s=1010 and r=0101 for one cycle; done at E2; err_bits=0, err=0.
- Next target 4'b1010: s=r=0000 in DRIVE (all HOLD); done, err_bits=0.
- Next target 4'b1001 after 1010: s=0001, r=0010, bits 3 and 2 HOLD; final q=1001.
- Force q_fb[2] stuck at 0 and send target 4'b0100: err_bits=0100 and err=1 with done. The next target 4'b0100 re-drives bit 2 (s[2]=1) because known[2] was cleared.
- rst asserted during DRIVE: next edge gives s=r=0, tgt_ready=1, err=0, no done. The first subsequent target drives all bits.
- Random targets back-to-back with tgt_valid held high for 1000 transfers: one acceptance every 3 cycles, s&r never nonzero, bank q always equals the last target.
